regfile_32x64: RTL and testbench
================================

Name: regfile_32x64

Overview:
- 32-entry × 64-bit architectural register file for the single-cycle LEGv8 datapath.
- Provides two combinational read ports and one clocked write port.
- Each read port is a 32:1 tree built from four of the team's existing 64-bit 8:1 muxes plus a 4:1 stage.
- The register array is the storage stage that feeds those read muxes.
- Read data drives the ALU operand path; write data comes from the writeback mux.

Parameters:
- DATA_WIDTH, 64, width of each register and of all data ports.
- NUM_REGS, 32, number of architectural registers. Fixed at 32; the address width is 5.
- ZERO_REG, 31, index hardwired to zero (XZR).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset. Sampled only on the rising edge of clk.
- RegWrite  input  1  write enable.
- WriteRegister  input  5  destination register index.
- WriteData  input  64  data to write.
- ReadRegister1  input  5  read port 1 index.
- ReadRegister2  input  5  read port 2 index.
- ReadData1  output  64  contents of ReadRegister1.
- ReadData2  output  64  contents of ReadRegister2.

Behaviour:
- Storage: 31 writable 64-bit registers, X0 through X30. X31 has no storage and always reads 64'h0.
- Reset:
  - On a rising edge with reset_n==0, all X0–X30 become 0.
  - After that edge, both ReadData outputs read 0 for every index.
  - Reset has priority over a simultaneous write; the write is discarded.
  - Reset asserted mid-program clears all state on the next edge, with no partial writes.
- Write:
  - On a rising edge with reset_n==1 and RegWrite==1, register[WriteRegister] <= WriteData.
  - No other register changes.
  - The write decoder is a 5:32 decoder gated by RegWrite. Exactly one enable is active, or none.
- Write to X31: silently dropped. X31 still reads 0 afterwards.
- RegWrite==0: no register changes, regardless of WriteRegister or WriteData.
- Read:
  - Purely combinational from the current register state.
  - ReadDataN = register[ReadRegisterN]; returns 0 when the index is 31.
  - Read latency is zero cycles; a new index is visible within the same cycle.
- Read-during-write, same index:
  - Before the edge, the read returns the old value. There is no write-through bypass.
  - The new value appears immediately after the edge.
- Both read ports may address the same register, or the register being written, with no interaction.
- Width: no sign or zero manipulation; all 64 bits are stored and returned verbatim.
- Implementation:
  - Each bit is a DFF with an enable mux (hold/load).
  - The enable comes from the decoder.
  - Synchronous reset is applied at the DFF input.
  - Read muxing uses the existing 2:1, 4:1 and 8:1 64-bit mux cells.

Test Plan:
1. Reset:
   - Stimulus: hold reset_n=0 for 1 edge with RegWrite=1, WriteRegister=5, WriteData=64'hDEAD.
   - Required: ReadRegister1=5 and ReadRegister2=0 both read 0.
2. Write/readback sweep:
   - Stimulus: release reset. For i=0..30, write WriteData=i*64'h0101_0101_0101_0101 with RegWrite=1, one per edge.
   - Required: sweeping ReadRegister1 and ReadRegister2 over 0..30 returns those values exactly.
3. XZR:
   - Stimulus: write 64'hFFFF_FFFF_FFFF_FFFF to WriteRegister=31.
   - Required: ReadRegister1=31 reads 0; X30 is unchanged.
4. Write-enable gating:
   - Stimulus: RegWrite=0, WriteRegister=3, WriteData=64'h1234 for 3 edges.
   - Required: X3 keeps its prior value of 3*64'h0101_0101_0101_0101.
5. Read-during-write:
   - Stimulus: X7 holds 64'hAAAA. Set ReadRegister1=7, WriteRegister=7, WriteData=64'h5555, RegWrite=1.
   - Required: ReadData1=64'hAAAA before the edge and 64'h5555 after it. ReadData2 (ReadRegister2=7) matches ReadData1.
6. Mid-run reset:
   - Stimulus: after scenario 2, drop reset_n for 1 edge.
   - Required: all X0–X31 read 0, and a subsequent write of 64'h42 to X1 reads back 64'h42.

Source files
------------

// File: rtl/regfile_32x64.sv
// 32 x 64-bit LEGv8 register file: two combinational read ports, one clocked write port.
// X31 (XZR) has no storage and always reads zero; reset is synchronous and active-low.

// 64-bit 2:1 mux cell.
// Latency: combinational.
// Backpressure: none.
module rf_mux2 #(
  parameter int W = 64
) (
  input  logic         sel,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  output logic [W-1:0] out
);
  assign out = sel ? in1 : in0;
endmodule

// 64-bit 4:1 mux cell, built from 2:1 cells.
// Latency: combinational.
// Backpressure: none.
module rf_mux4 #(
  parameter int W = 64
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] in3,
  output logic [W-1:0] out
);
  logic [W-1:0] lo_dat;
  logic [W-1:0] hi_dat;

  rf_mux2 #(.W(W)) u_lo  (.sel(sel[0]), .in0(in0),    .in1(in1),    .out(lo_dat));
  rf_mux2 #(.W(W)) u_hi  (.sel(sel[0]), .in0(in2),    .in1(in3),    .out(hi_dat));
  rf_mux2 #(.W(W)) u_out (.sel(sel[1]), .in0(lo_dat), .in1(hi_dat), .out(out));
endmodule

// 64-bit 8:1 mux cell, built from two 4:1 cells and a 2:1 cell.
// Latency: combinational.
// Backpressure: none.
module rf_mux8 #(
  parameter int W = 64
) (
  input  logic [2:0]   sel,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] in3,
  input  logic [W-1:0] in4,
  input  logic [W-1:0] in5,
  input  logic [W-1:0] in6,
  input  logic [W-1:0] in7,
  output logic [W-1:0] out
);
  logic [W-1:0] lo_dat;
  logic [W-1:0] hi_dat;

  rf_mux4 #(.W(W)) u_lo (
    .sel(sel[1:0]), .in0(in0), .in1(in1), .in2(in2), .in3(in3), .out(lo_dat)
  );
  rf_mux4 #(.W(W)) u_hi (
    .sel(sel[1:0]), .in0(in4), .in1(in5), .in2(in6), .in3(in7), .out(hi_dat)
  );
  rf_mux2 #(.W(W)) u_out (.sel(sel[2]), .in0(lo_dat), .in1(hi_dat), .out(out));
endmodule

// 5:N write decoder gated by the write enable; at most one output is high.
// Latency: combinational.
// Backpressure: none; addresses at or above N decode to no enable.
module rf_wr_dec #(
  parameter int N = 31
) (
  input  logic         en,
  input  logic [4:0]   addr,
  output logic [N-1:0] sel
);
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (en && (addr == 5'(i))) begin
        sel[i] = 1'b1;
      end
    end
  end
endmodule

// One architectural register: DFF with hold/load mux and synchronous active-low clear.
// Latency: new value visible one clock after load.
// Backpressure: none.
module rf_reg #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_dat,
  output logic [W-1:0] reg_dat
);
  logic [W-1:0] reg_d;
  logic [W-1:0] reg_q;

  always_comb begin
    reg_d = reg_q;
    if (load) begin
      reg_d = load_dat;
    end
  end

  // Clear wins over load, so a write on a reset edge is discarded.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      reg_q <= '0;
    end else begin
      reg_q <= reg_d;
    end
  end

  assign reg_dat = reg_q;
endmodule

// 32:1 read port: four 8:1 cells select within a bank, a 4:1 cell selects the bank.
// Latency: combinational.
// Backpressure: none.
module rf_rd_port #(
  parameter int W = 64
) (
  input  logic [31:0][W-1:0] regs,
  input  logic [4:0]         addr,
  output logic [W-1:0]       dat
);
  logic [3:0][W-1:0] bank_dat;

  for (genvar b = 0; b < 4; b++) begin : g_bank
    rf_mux8 #(.W(W)) u_mux8 (
      .sel(addr[2:0]),
      .in0(regs[b*8+0]), .in1(regs[b*8+1]), .in2(regs[b*8+2]), .in3(regs[b*8+3]),
      .in4(regs[b*8+4]), .in5(regs[b*8+5]), .in6(regs[b*8+6]), .in7(regs[b*8+7]),
      .out(bank_dat[b])
    );
  end

  rf_mux4 #(.W(W)) u_bank_sel (
    .sel(addr[4:3]),
    .in0(bank_dat[0]), .in1(bank_dat[1]), .in2(bank_dat[2]), .in3(bank_dat[3]),
    .out(dat)
  );
endmodule

// Register file top: decoder -> 31 storage registers + hardwired XZR -> two read trees.
// Latency: reads combinational (no write-through), writes land on the rising edge.
// Backpressure: none; writes to X31 are dropped.
module regfile_32x64 #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REGS   = 32,
  parameter int ZERO_REG   = 31
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  RegWrite,
  input  logic [4:0]            WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [4:0]            ReadRegister1,
  input  logic [4:0]            ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
  logic [NUM_REGS-2:0]                 wr_sel;

  // Decoder covers X0..X30 only; index 31 produces no enable.
  rf_wr_dec #(.N(NUM_REGS - 1)) u_wr_dec (
    .en  (RegWrite),
    .addr(WriteRegister),
    .sel (wr_sel)
  );

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    if (g == ZERO_REG) begin : g_xzr
      assign regs[g] = '0;
    end else begin : g_store
      rf_reg #(.W(DATA_WIDTH)) u_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (wr_sel[g]),
        .load_dat(WriteData),
        .reg_dat (regs[g])
      );
    end
  end

  rf_rd_port #(.W(DATA_WIDTH)) u_rd1 (
    .regs(regs),
    .addr(ReadRegister1),
    .dat (ReadData1)
  );

  rf_rd_port #(.W(DATA_WIDTH)) u_rd2 (
    .regs(regs),
    .addr(ReadRegister2),
    .dat (ReadData2)
  );
endmodule

// File: tb/tb_regfile_32x64.sv
// Directed bench for regfile_32x64 with an array model checked every negedge.
module tb_regfile_32x64;
  localparam logic [63:0] K = 64'h0101_0101_0101_0101;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [63:0] model [0:30];

  regfile_32x64 dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .RegWrite     (RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData),
    .ReadRegister1(ReadRegister1),
    .ReadRegister2(ReadRegister2),
    .ReadData1    (ReadData1),
    .ReadData2    (ReadData2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_rd(input logic [4:0] idx);
    return (idx == 5'd31) ? 64'h0 : model[idx];
  endfunction

  // Architectural model: state changes only on a rising edge.
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 31; i++) model[i] = 64'h0;
    end else if (RegWrite && WriteRegister != 5'd31) begin
      model[WriteRegister] = WriteData;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_rd1", ReadData1, model_rd(ReadRegister1));
      check("model_rd2", ReadData2, model_rd(ReadRegister2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    reset_n       = 1'b0;
    RegWrite      = 1'b1;
    WriteRegister = 5'd5;
    WriteData     = 64'hDEAD;
    ReadRegister1 = 5'd5;
    ReadRegister2 = 5'd0;

    // 1: reset edge beats a simultaneous write to X5
    tick();
    chk_en = 1'b1;
    #2;
    check("reset_rd1_x5", ReadData1, 64'h0);
    check("reset_rd2_x0", ReadData2, 64'h0);

    // 2: write sweep then readback sweep on both ports
    reset_n = 1'b1;
    for (int i = 0; i < 31; i++) begin
      WriteRegister = 5'(i);
      WriteData     = K * 64'(i);
      tick();
    end
    RegWrite = 1'b0;
    for (int i = 0; i < 31; i++) begin
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(30 - i);
      #2;
      check("sweep_rd1", ReadData1, K * 64'(i));
      check("sweep_rd2", ReadData2, K * 64'(30 - i));
      tick();
    end
    ReadRegister1 = 5'd30;
    #2;
    check("sweep_x30_literal", ReadData1, 64'h1E1E_1E1E_1E1E_1E1E);
    tick();

    // 3: XZR write dropped
    RegWrite      = 1'b1;
    WriteRegister = 5'd31;
    WriteData     = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    RegWrite      = 1'b0;
    ReadRegister1 = 5'd31;
    ReadRegister2 = 5'd30;
    #2;
    check("xzr_rd1", ReadData1, 64'h0);
    check("xzr_x30", ReadData2, 64'h1E1E_1E1E_1E1E_1E1E);
    tick();

    // 4: RegWrite low blocks writes
    WriteRegister = 5'd3;
    WriteData     = 64'h1234;
    repeat (3) tick();
    ReadRegister1 = 5'd3;
    #2;
    check("wen_gate_x3", ReadData1, 64'h0303_0303_0303_0303);
    tick();

    // 5: read-during-write, no bypass
    RegWrite      = 1'b1;
    WriteRegister = 5'd7;
    WriteData     = 64'hAAAA;
    tick();
    WriteData     = 64'h5555;
    ReadRegister1 = 5'd7;
    ReadRegister2 = 5'd7;
    #2;
    check("rdw_before_rd1", ReadData1, 64'hAAAA);
    check("rdw_before_rd2", ReadData2, 64'hAAAA);
    tick();
    RegWrite = 1'b0;
    #2;
    check("rdw_after_rd1", ReadData1, 64'h5555);
    check("rdw_after_rd2", ReadData2, 64'h5555);
    tick();

    // 6: mid-run reset with a competing write, then a fresh write
    reset_n       = 1'b0;
    RegWrite      = 1'b1;
    WriteRegister = 5'd9;
    WriteData     = 64'h9999;
    tick();
    reset_n  = 1'b1;
    RegWrite = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(31 - i);
      #2;
      check("midreset_rd1", ReadData1, 64'h0);
      check("midreset_rd2", ReadData2, 64'h0);
      tick();
    end
    RegWrite      = 1'b1;
    WriteRegister = 5'd1;
    WriteData     = 64'h42;
    tick();
    RegWrite      = 1'b0;
    ReadRegister1 = 5'd1;
    ReadRegister2 = 5'd9;
    #2;
    check("post_reset_x1", ReadData1, 64'h42);
    check("post_reset_x9", ReadData2, 64'h0);
    tick();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
